bsg_manycore_stat_snoop_multi: RTL and testbench

Multi-link successor to the single-link print-stat snoop in the manycore testbench top. Watches `num_links_p` host/edge link request streams for stores to the print-stat EPA and timestamps each hit with the global cycle counter. Each hit goes through a per-link capture slot and a round-robin arbiter into a shared FIFO, which the DPI host drains. Lost events are counted instead of being silently merged.

---
 rtl/bsg_manycore_stat_snoop_multi.sv | 167 ++++++++++++++++
 tb/tb_bsg_manycore_stat_snoop_multi.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_stat_snoop_multi.sv
// Print-stat snoop for several host/edge links.
// Every link's request stream is checked for stores to the print-stat EPA.
// Each hit is timestamped with ctr_i and placed in a capture slot for that link.
// A round-robin arbiter moves one full slot per cycle into a shared FIFO,
// which the host drains through v_o/yumi_i.
// A hit that finds its slot still occupied is counted as a drop; it is not
// merged into the pending entry.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   en_i                snoop enable
//   ctr_i               global cycle counter, captured as the timestamp
//   snoop_*_i           per-link handshake, store flag, EPA and store data
//   v_o/link_o/tag_o/time_o, yumi_i   FIFO head and consume strobe
//   count_o             FIFO occupancy
//   drop_count_o        saturating count of dropped hits
module bsg_manycore_stat_snoop_multi #(
  parameter int num_links_p = 4,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int ctr_width_p = 64,
  parameter int els_p = 8,
  parameter int drop_width_p = 16,
  parameter logic [addr_width_p-1:0] print_stat_epa_p = 'h0D0C,
  localparam int lg_links_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1,
  localparam int cnt_width_lp = $clog2(els_p+1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [ctr_width_p-1:0]            ctr_i,
  input  logic [num_links_p-1:0]            snoop_v_i,
  input  logic [num_links_p-1:0]            snoop_store_i,
  input  logic [num_links_p*addr_width_p-1:0] snoop_addr_i,
  input  logic [num_links_p*data_width_p-1:0] snoop_data_i,
  output logic                              v_o,
  output logic [lg_links_lp-1:0]            link_o,
  output logic [data_width_p-1:0]           tag_o,
  output logic [ctr_width_p-1:0]            time_o,
  input  logic                              yumi_i,
  output logic [cnt_width_lp-1:0]           count_o,
  output logic [drop_width_p-1:0]           drop_count_o
);

  localparam int ptr_width_lp   = $clog2(els_p);
  localparam int entry_width_lp = lg_links_lp + data_width_p + ctr_width_p;
  localparam int pop_width_lp   = $clog2(num_links_p+1);
  localparam int sum_width_lp   = drop_width_p + pop_width_lp;
  localparam logic [cnt_width_lp-1:0] els_lp      = cnt_width_lp'(els_p);
  localparam logic [lg_links_lp-1:0]  last_rst_lp = lg_links_lp'(num_links_p-1);

  logic [num_links_p-1:0]  hit, load, drop, grant_oh;
  logic [num_links_p-1:0]  slot_full_q, slot_full_d;
  logic [data_width_p-1:0] slot_tag_q  [num_links_p];
  logic [data_width_p-1:0] slot_tag_d  [num_links_p];
  logic [ctr_width_p-1:0]  slot_time_q [num_links_p];
  logic [ctr_width_p-1:0]  slot_time_d [num_links_p];

  logic [lg_links_lp-1:0]  last_q, last_d, grant_idx;
  logic                    grant_v, arb_en;
  int unsigned             arb_idx;

  logic [entry_width_lp-1:0] mem_q [els_p];
  logic [entry_width_lp-1:0] mem_d [els_p];
  logic [entry_width_lp-1:0] head;
  logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [cnt_width_lp-1:0]   count_q, count_d;
  logic                      pop_v;

  logic [drop_width_p-1:0] drop_q, drop_d;
  logic [pop_width_lp-1:0] drop_pop;
  logic [sum_width_lp-1:0] drop_sum;

  // Round-robin search starting one past the last granted link.
  // A simultaneous yumi frees a FIFO entry, so a grant is allowed even at full.
  always_comb begin
    arb_en    = (count_q != els_lp) | yumi_i;
    grant_v   = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int unsigned off = 1; off <= num_links_p; off++) begin
      arb_idx = 32'(last_q) + off;
      if (arb_idx >= unsigned'(num_links_p)) arb_idx = arb_idx - unsigned'(num_links_p);
      if (arb_en && !grant_v && slot_full_q[arb_idx[lg_links_lp-1:0]]) begin
        grant_v   = 1'b1;
        grant_idx = arb_idx[lg_links_lp-1:0];
      end
    end
    grant_oh = '0;
    if (grant_v) grant_oh[grant_idx] = 1'b1;
    last_d = grant_v ? grant_idx : last_q;
  end

  // A slot being granted this cycle can take a new hit in the same cycle.
  always_comb begin
    hit         = '0;
    load        = '0;
    drop        = '0;
    drop_pop    = '0;
    slot_full_d = slot_full_q;
    slot_tag_d  = slot_tag_q;
    slot_time_d = slot_time_q;
    for (int unsigned i = 0; i < num_links_p; i++) begin
      hit[i]  = en_i & snoop_v_i[i] & snoop_store_i[i]
              & (snoop_addr_i[i*addr_width_p +: addr_width_p] == print_stat_epa_p);
      load[i] = hit[i] & (~slot_full_q[i] | grant_oh[i]);
      drop[i] = hit[i] & slot_full_q[i] & ~grant_oh[i];
      slot_full_d[i] = load[i] | (slot_full_q[i] & ~grant_oh[i]);
      if (load[i]) begin
        slot_tag_d[i]  = snoop_data_i[i*data_width_p +: data_width_p];
        slot_time_d[i] = ctr_i;
      end
      drop_pop = drop_pop + pop_width_lp'(drop[i]);
    end
    drop_sum = sum_width_lp'(drop_q) + sum_width_lp'(drop_pop);
    drop_d   = (drop_sum > sum_width_lp'({drop_width_p{1'b1}}))
             ? '1 : drop_sum[drop_width_p-1:0];
  end

  // At full occupancy with write and pop together, wr_ptr equals rd_ptr.
  // The head is consumed at that edge, so overwriting its cell is safe.
  always_comb begin
    pop_v = yumi_i & (count_q != '0);
    mem_d = mem_q;
    if (grant_v) mem_d[wr_ptr_q] = {grant_idx, slot_tag_q[grant_idx], slot_time_q[grant_idx]};
    wr_ptr_d = wr_ptr_q + ptr_width_lp'(grant_v);
    rd_ptr_d = rd_ptr_q + ptr_width_lp'(pop_v);
    count_d  = count_q + cnt_width_lp'(grant_v) - cnt_width_lp'(pop_v);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_full_q <= '0;
      for (int unsigned i = 0; i < num_links_p; i++) begin
        slot_tag_q[i]  <= '0;
        slot_time_q[i] <= '0;
      end
      last_q   <= last_rst_lp;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_tag_q  <= slot_tag_d;
      slot_time_q <= slot_time_d;
      last_q      <= last_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
    end
  end

  // Storage only; validity comes from count_q, which is reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    v_o  = (count_q != '0);
    {link_o, tag_o, time_o} = v_o ? head : '0;
    count_o      = count_q;
    drop_count_o = drop_q;
  end

endmodule

// File: tb/tb_bsg_manycore_stat_snoop_multi.sv
module tb_bsg_manycore_stat_snoop_multi;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int CW = 64;
  localparam int E  = 8;
  localparam logic [AW-1:0] EPA = 28'h0D0C;

  logic clk, reset_i, en_i, yumi_i;
  logic [CW-1:0] ctr_i;
  logic [N-1:0] snoop_v_i, snoop_store_i;
  logic [N*AW-1:0] snoop_addr_i;
  logic [N*DW-1:0] snoop_data_i;

  logic v_o, sat_v_o;
  logic [1:0] link_o, sat_link_o;
  logic [DW-1:0] tag_o, sat_tag_o;
  logic [CW-1:0] time_o, sat_time_o;
  logic [3:0] count_o, sat_count_o;
  logic [15:0] drop_count_o;
  logic [1:0] sat_drop_count_o;

  bsg_manycore_stat_snoop_multi #(.num_links_p(N), .addr_width_p(AW), .data_width_p(DW),
    .ctr_width_p(CW), .els_p(E), .drop_width_p(16), .print_stat_epa_p(EPA)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .ctr_i(ctr_i),
    .snoop_v_i(snoop_v_i), .snoop_store_i(snoop_store_i),
    .snoop_addr_i(snoop_addr_i), .snoop_data_i(snoop_data_i),
    .v_o(v_o), .link_o(link_o), .tag_o(tag_o), .time_o(time_o), .yumi_i(yumi_i),
    .count_o(count_o), .drop_count_o(drop_count_o));

  bsg_manycore_stat_snoop_multi #(.num_links_p(N), .addr_width_p(AW), .data_width_p(DW),
    .ctr_width_p(CW), .els_p(E), .drop_width_p(2), .print_stat_epa_p(EPA)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .ctr_i(ctr_i),
    .snoop_v_i(snoop_v_i), .snoop_store_i(snoop_store_i),
    .snoop_addr_i(snoop_addr_i), .snoop_data_i(snoop_data_i),
    .v_o(sat_v_o), .link_o(sat_link_o), .tag_o(sat_tag_o), .time_o(sat_time_o), .yumi_i(yumi_i),
    .count_o(sat_count_o), .drop_count_o(sat_drop_count_o));

  always #5 clk = ~clk;

  // Reference model: slots as arrays, FIFO as a queue.
  typedef struct {int link; logic [DW-1:0] tag; logic [CW-1:0] tm;} ent_t;
  ent_t q[$];
  bit m_full[N];
  logic [DW-1:0] m_tag[N];
  logic [CW-1:0] m_time[N];
  int m_last, m_drop, m_drop2;
  logic [CW-1:0] cyc;
  int n_checks, n_fail;

  function automatic void model_clear();
    q.delete();
    for (int i = 0; i < N; i++) m_full[i] = 0;
    m_last = N - 1;
    m_drop = 0;
    m_drop2 = 0;
  endfunction

  function automatic logic [120:0] model_out();
    logic [98:0] h;
    h = '0;
    if (q.size() > 0) h = {1'b1, 2'(q[0].link), q[0].tag, q[0].tm};
    return {h, 4'(q.size()), 16'(m_drop), 2'(m_drop2)};
  endfunction

  function automatic logic [120:0] dut_out();
    return {v_o, link_o, tag_o, time_o, count_o, drop_count_o, sat_drop_count_o};
  endfunction

  task automatic set_hit(input int i, input logic [DW-1:0] tag);
    snoop_v_i[i] = 1'b1;
    snoop_store_i[i] = 1'b1;
    snoop_addr_i[i*AW +: AW] = EPA;
    snoop_data_i[i*DW +: DW] = tag;
  endtask

  // Advance model by one clock using the currently driven inputs, then clock the DUT.
  task automatic cycle();
    int g, drops, j;
    bit hit;
    ent_t e;
    g = -1;
    if (q.size() < E || yumi_i)
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (g < 0 && m_full[j]) g = j;
      end
    if (yumi_i && q.size() > 0) void'(q.pop_front());
    if (g >= 0) begin
      e.link = g; e.tag = m_tag[g]; e.tm = m_time[g];
      q.push_back(e);
      m_last = g;
    end
    drops = 0;
    for (int i = 0; i < N; i++) begin
      hit = en_i && snoop_v_i[i] && snoop_store_i[i] && (snoop_addr_i[i*AW +: AW] == EPA);
      if (hit) begin
        if (!m_full[i] || g == i) begin
          m_full[i] = 1; m_tag[i] = snoop_data_i[i*DW +: DW]; m_time[i] = ctr_i;
        end else drops++;
      end else if (g == i) m_full[i] = 0;
    end
    m_drop  = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    m_drop2 = (m_drop2 + drops > 3) ? 3 : m_drop2 + drops;
    @(posedge clk); #1;
    cyc = cyc + 1;
    ctr_i = cyc;
    snoop_v_i = '0;
    snoop_store_i = '0;
    yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    model_clear();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (dut_out() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", dut_out());
    end
    reset_i = 1'b0;
    en_i = 1'b1;
    set_hit(0, 32'hABCD);
    cycle();
    cycle();
    n_checks++;
    if (v_o !== 1'b1 || link_o !== 2'd0 || tag_o !== 32'hABCD) begin
      n_fail++; $display("FAIL first_edge_hit: got v=%b link=%0d tag=%h expected v=1 link=0 tag=abcd", v_o, link_o, tag_o);
    end
    yumi_i = 1'b1;
    cycle();
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++; $display("FAIL reset_drain: got %h expected %h", dut_out(), model_out());
    end
  endtask

  task automatic test_single_hit();
    cyc = 100; ctr_i = cyc;
    set_hit(2, 32'h1234);
    cycle();
    n_checks++;
    if (v_o !== 1'b0) begin n_fail++; $display("FAIL single_latency1: got v=%b expected 0", v_o); end
    cycle();
    n_checks++;
    if (v_o !== 1'b1 || link_o !== 2'd2 || tag_o !== 32'h1234 || time_o !== 64'd100) begin
      n_fail++; $display("FAIL single_head: got v=%b link=%0d tag=%h time=%0d expected 1/2/1234/100", v_o, link_o, tag_o, time_o);
    end
    yumi_i = 1'b1;
    cycle();
    n_checks++;
    if (v_o !== 1'b0 || count_o !== 4'd0) begin
      n_fail++; $display("FAIL single_yumi: got v=%b count=%0d expected 0/0", v_o, count_o);
    end
  endtask

  task automatic test_burst();
    int exp_link[7] = '{0, 1, 2, 3, 0, 1, 2};
    logic [DW-1:0] exp_tag[7] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22};
    do_reset();
    for (int i = 0; i < N; i++) set_hit(i, 32'h10 + i);
    cycle();
    cycle();
    cycle();
    for (int i = 0; i < N; i++) set_hit(i, 32'h20 + i);
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++; $display("FAIL burst_model: got %h expected %h", dut_out(), model_out());
      end
    end
    n_checks++;
    if (count_o !== 4'd7 || drop_count_o !== 16'd1) begin
      n_fail++; $display("FAIL burst_fill: got count=%0d drops=%0d expected 7/1", count_o, drop_count_o);
    end
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (v_o !== 1'b1 || 32'(link_o) !== exp_link[k] || tag_o !== exp_tag[k]) begin
        n_fail++; $display("FAIL burst_order[%0d]: got v=%b link=%0d tag=%h expected link=%0d tag=%h",
                           k, v_o, link_o, tag_o, exp_link[k], exp_tag[k]);
      end
      yumi_i = 1'b1;
      cycle();
    end
  endtask

  task automatic test_no_capture();
    logic [15:0] d0;
    d0 = drop_count_o;
    set_hit(1, 32'h55); snoop_addr_i[1*AW +: AW] = EPA + 28'd4;
    cycle();
    set_hit(1, 32'h56); snoop_store_i[1] = 1'b0;
    cycle();
    en_i = 1'b0;
    set_hit(1, 32'h57);
    cycle();
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++; $display("FAIL nocap_model: got %h expected %h", dut_out(), model_out());
      end
    end
    n_checks++;
    if (v_o !== 1'b0 || count_o !== 4'd0 || drop_count_o !== d0) begin
      n_fail++; $display("FAIL nocap: got v=%b count=%0d drops=%0d expected 0/0/%0d", v_o, count_o, drop_count_o, d0);
    end
  endtask

  task automatic test_fifo_fill();
    int d0;
    d0 = m_drop;
    for (int k = 0; k < 10; k++) begin
      set_hit(0, 32'h100 + k);
      cycle();
    end
    cycle();
    cycle();
    n_checks++;
    if (count_o !== 4'd8 || drop_count_o !== 16'(d0 + 1) || tag_o !== 32'h100) begin
      n_fail++; $display("FAIL fill: got count=%0d drops=%0d head=%h expected 8/%0d/100", count_o, drop_count_o, tag_o, d0 + 1);
    end
    yumi_i = 1'b1;
    cycle();
    n_checks++;
    if (count_o !== 4'd8 || tag_o !== 32'h101) begin
      n_fail++; $display("FAIL fill_yumi: got count=%0d head=%h expected 8/101", count_o, tag_o);
    end
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++; $display("FAIL fill_model: got %h expected %h", dut_out(), model_out());
    end
  endtask

  task automatic test_drop_sat();
    int d0;
    d0 = m_drop;
    for (int k = 0; k < 6; k++) begin
      set_hit(0, 32'h200 + k);
      cycle();
    end
    cycle();
    cycle();
    n_checks++;
    if (drop_count_o !== 16'(d0 + 5) || sat_drop_count_o !== 2'd3) begin
      n_fail++; $display("FAIL drop_sat: got drops=%0d sat=%0d expected %0d/3", drop_count_o, sat_drop_count_o, d0 + 5);
    end
    n_checks++;
    if (dut_out() !== model_out()) begin
      n_fail++; $display("FAIL drop_model: got %h expected %h", dut_out(), model_out());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) set_hit(i, 32'h30 + i);
    repeat (4) cycle();
    set_hit(0, 32'h40);
    set_hit(3, 32'h43);
    cycle();
    n_checks++;
    if (count_o !== 4'd3 || dut_out() !== model_out()) begin
      n_fail++; $display("FAIL pre_reset: got %h expected %h", dut_out(), model_out());
    end
    reset_i = 1'b1;
    #1;
    model_clear();
    n_checks++;
    if (v_o !== 1'b0 || count_o !== 4'd0 || drop_count_o !== 16'd0 || dut_out() !== '0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0", dut_out());
    end
    reset_i = 1'b0;
    set_hit(3, 32'h33);
    cycle();
    set_hit(0, 32'h44);
    cycle();
    n_checks++;
    if (v_o !== 1'b1 || link_o !== 2'd3 || tag_o !== 32'h33) begin
      n_fail++; $display("FAIL post_reset_first: got v=%b link=%0d tag=%h expected 1/3/33", v_o, link_o, tag_o);
    end
    yumi_i = 1'b1;
    cycle();
    n_checks++;
    if (v_o !== 1'b1 || link_o !== 2'd0 || tag_o !== 32'h44) begin
      n_fail++; $display("FAIL post_reset_second: got v=%b link=%0d tag=%h expected 1/0/44", v_o, link_o, tag_o);
    end
  endtask

  task automatic test_random();
    int phase;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      phase = (c / 150) % 3;
      en_i = ($urandom % 8) != 0;
      for (int i = 0; i < N; i++) begin
        snoop_v_i[i] = ($urandom % 3) == 0;
        snoop_store_i[i] = ($urandom % 4) != 0;
        snoop_addr_i[i*AW +: AW] = (($urandom % 4) != 0) ? EPA : AW'($urandom);
        snoop_data_i[i*DW +: DW] = $urandom;
      end
      yumi_i = (q.size() > 0) && ((phase == 0) ? (($urandom % 4) != 0)
                                : (phase == 1) ? (($urandom % 4) == 0) : 1'b0);
      if ((c % 700) == 699) do_reset();
      cycle();
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", c, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    clk = 1'b0; reset_i = 1'b1; en_i = 1'b0; yumi_i = 1'b0;
    snoop_v_i = '0; snoop_store_i = '0; snoop_addr_i = '0; snoop_data_i = '0;
    cyc = '0; ctr_i = '0;
    n_checks = 0; n_fail = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_hit();
    test_burst();
    test_no_capture();
    test_fifo_fill();
    test_drop_sat();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
